// File: rtl/decode_queue_if.sv
// decode_queue_if -- handshake bundle between the fetch side, the decode
// queue and the execute side.
//   FLUSH                      : synchronous discard of all buffered entries
//   IN_VALID/IN_READY          : fetch-side push handshake
//   IN_INSTR, IN_PC            : raw RV32 instruction and its address
//   OUT_VALID/OUT_READY        : execute-side pop handshake
//   OUT_RD/RS1/RS2, OUT_IMM,
//   OUT_FMT, OUT_ALU_OP,
//   OUT_ILLEGAL, OUT_PC        : decoded head entry
//   COUNT                      : occupancy, $clog2(DEPTH)+1 bits
// DEPTH/PC_W must match the decode_queue instance bound to this interface.
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            FLUSH;
  logic            IN_VALID;
  logic            IN_READY;
  logic [31:0]     IN_INSTR;
  logic [PC_W-1:0] IN_PC;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [4:0]      OUT_RD;
  logic [4:0]      OUT_RS1;
  logic [4:0]      OUT_RS2;
  logic [31:0]     OUT_IMM;
  logic [2:0]      OUT_FMT;
  logic [4:0]      OUT_ALU_OP;
  logic            OUT_ILLEGAL;
  logic [PC_W-1:0] OUT_PC;
  logic [CW-1:0]   COUNT;

  // queue side
  modport slave (
    input  FLUSH, IN_VALID, IN_INSTR, IN_PC, OUT_READY,
    output IN_READY, OUT_VALID, OUT_RD, OUT_RS1, OUT_RS2, OUT_IMM,
           OUT_FMT, OUT_ALU_OP, OUT_ILLEGAL, OUT_PC, COUNT
  );

  // fetch + execute side
  modport master (
    output FLUSH, IN_VALID, IN_INSTR, IN_PC, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_RD, OUT_RS1, OUT_RS2, OUT_IMM,
           OUT_FMT, OUT_ALU_OP, OUT_ILLEGAL, OUT_PC, COUNT
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue -- RV32I decoder feeding a DEPTH-entry circular buffer.
// Each accepted instruction is decoded combinationally on the way in and the
// decoded record (register indices, immediate, format, ALU op, illegal flag,
// PC) is stored; the head record is presented one cycle after the push.
//
// Ports:
//   CLK    : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   qif    : decode_queue_if.slave (push/pop handshakes, decoded head, COUNT)
//
// Parameters: DEPTH (power of two, 2..16), PC_W.
// Build option: define DECODE_QUEUE_RV32M_EN to decode the RV32M
// multiply/divide group (ALU ops 24..31); otherwise it decodes as illegal.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic             CLK,
  input logic             RST_N,
  decode_queue_if.slave   qif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef DECODE_QUEUE_RV32M_EN
  localparam logic [6:0] F7_MUL  = 7'b0000001;
`endif

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_LUI   = 5'd10;
  localparam logic [4:0] ALU_AUIPC = 5'd11;
  localparam logic [4:0] ALU_JAL   = 5'd12;
  localparam logic [4:0] ALU_JALR  = 5'd13;
  localparam logic [4:0] ALU_BEQ   = 5'd14;
  localparam logic [4:0] ALU_BNE   = 5'd15;
  localparam logic [4:0] ALU_BLT   = 5'd16;
  localparam logic [4:0] ALU_BGE   = 5'd17;
  localparam logic [4:0] ALU_BLTU  = 5'd18;
  localparam logic [4:0] ALU_BGEU  = 5'd19;
  localparam logic [4:0] ALU_LOAD  = 5'd20;
  localparam logic [4:0] ALU_STORE = 5'd21;

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [2:0]      fmt;
    logic [4:0]      alu_op;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr = qif.IN_INSTR;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [31:0] dec_imm;
  logic [2:0]  dec_fmt;
  logic [4:0]  dec_alu;
  logic        dec_ill;

  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_R;
    dec_alu = ALU_ADD;
    dec_ill = 1'b0;
    unique case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          unique case (f3)
            3'd0:    dec_alu = ALU_ADD;
            3'd1:    dec_alu = ALU_SLL;
            3'd2:    dec_alu = ALU_SLT;
            3'd3:    dec_alu = ALU_SLTU;
            3'd4:    dec_alu = ALU_XOR;
            3'd5:    dec_alu = ALU_SRL;
            3'd6:    dec_alu = ALU_OR;
            default: dec_alu = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'd0) begin
          dec_alu = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'd5) begin
          dec_alu = ALU_SRA;
`ifdef DECODE_QUEUE_RV32M_EN
        end else if (f7 == F7_MUL) begin
          // MUL..REMU occupy 24..31 in funct3 order
          dec_alu = {2'b11, f3};
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        unique case (f3)
          3'd0: dec_alu = ALU_ADD;
          3'd1: begin
            // shift-immediates reuse imm[11:5] as a funct7 qualifier
            if (f7 == F7_BASE) dec_alu = ALU_SLL;
            else               dec_ill = 1'b1;
          end
          3'd2: dec_alu = ALU_SLT;
          3'd3: dec_alu = ALU_SLTU;
          3'd4: dec_alu = ALU_XOR;
          3'd5: begin
            if      (f7 == F7_BASE) dec_alu = ALU_SRL;
            else if (f7 == F7_ALT)  dec_alu = ALU_SRA;
            else                    dec_ill = 1'b1;
          end
          3'd6:    dec_alu = ALU_OR;
          default: dec_alu = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        dec_alu = ALU_LOAD;
        // LB, LH, LW, LBU, LHU only
        dec_ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        dec_alu = ALU_JALR;
        dec_ill = (f3 != 3'd0);
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = imm_s;
        dec_alu = ALU_STORE;
        dec_ill = (f3 > 3'd2);
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = imm_b;
        unique case (f3)
          3'd0:    dec_alu = ALU_BEQ;
          3'd1:    dec_alu = ALU_BNE;
          3'd4:    dec_alu = ALU_BLT;
          3'd5:    dec_alu = ALU_BGE;
          3'd6:    dec_alu = ALU_BLTU;
          3'd7:    dec_alu = ALU_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_fmt = FMT_U;
        dec_imm = imm_u;
        dec_alu = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = imm_u;
        dec_alu = ALU_AUIPC;
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = imm_j;
        dec_alu = ALU_JAL;
      end
      // FENCE, SYSTEM and anything non-RV32I are not handled downstream
      default: dec_ill = 1'b1;
    endcase
    // illegal entries still travel in order but must not trigger an ALU op
    if (dec_ill) dec_alu = ALU_ADD;
  end

  entry_t dec;
  always_comb begin
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.imm     = dec_imm;
    dec.fmt     = dec_fmt;
    dec.alu_op  = dec_alu;
    dec.illegal = dec_ill;
    dec.pc      = qif.IN_PC;
  end

  // ----------------------------------------------------------------- queue
  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          in_ready, out_valid, push, pop;

  // IN_READY is a pure function of occupancy, so a full queue refuses a push
  // even on an edge where it also pops.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = qif.IN_VALID && in_ready;
  assign pop       = out_valid && qif.OUT_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (qif.FLUSH) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge CLK) begin
    if (push && !qif.FLUSH) mem[wptr] <= dec;
  end

  entry_t head;
  assign head = out_valid ? mem[rptr] : '0;

  assign qif.IN_READY    = in_ready;
  assign qif.OUT_VALID   = out_valid;
  assign qif.OUT_RD      = head.rd;
  assign qif.OUT_RS1     = head.rs1;
  assign qif.OUT_RS2     = head.rs2;
  assign qif.OUT_IMM     = head.imm;
  assign qif.OUT_FMT     = head.fmt;
  assign qif.OUT_ALU_OP  = head.alu_op;
  assign qif.OUT_ILLEGAL = head.illegal;
  assign qif.OUT_PC      = head.pc;
  assign qif.COUNT       = count;
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic CLK;
  logic RST_N;
  decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) qif ();
  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.CLK(CLK), .RST_N(RST_N), .qif(qif));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------- reference model
  typedef struct {
    logic [31:0] imm;
    int          fmt;
    int          alu;
    bit          ill;
  } ref_t;

  function automatic ref_t ref_dec(input logic [31:0] w);
    ref_t d;
    logic [9:0] key;
    int br_tab [8] = '{14, 15, -1, -1, 16, 17, 18, 19};
    int r_tab  [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int i_tab  [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int f3;
    d.imm = 0; d.fmt = 0; d.alu = 0; d.ill = 0;
    f3  = int'(w[14:12]);
    key = {w[31:25], w[14:12]};
    case (w[6:0])
      7'h33: begin
        if (w[31:25] == 7'h00) d.alu = r_tab[f3];
        else if (key == 10'b0100000_000) d.alu = 1;
        else if (key == 10'b0100000_101) d.alu = 7;
`ifdef DECODE_QUEUE_RV32M_EN
        else if (w[31:25] == 7'h01) d.alu = 24 + f3;
`endif
        else d.ill = 1;
      end
      7'h13: begin
        d.fmt = 1; d.imm = 32'($signed(w[31:20]));
        if (f3 == 1)      d.ill = (w[31:25] != 0);
        else if (f3 == 5) d.ill = (w[31:25] != 0) && (w[31:25] != 7'h20);
        d.alu = (f3 == 5 && w[30]) ? 7 : i_tab[f3];
      end
      7'h03: begin d.fmt = 1; d.imm = 32'($signed(w[31:20])); d.alu = 20; d.ill = !(f3 inside {0, 1, 2, 4, 5}); end
      7'h67: begin d.fmt = 1; d.imm = 32'($signed(w[31:20])); d.alu = 13; d.ill = (f3 != 0); end
      7'h23: begin d.fmt = 2; d.imm = 32'($signed({w[31:25], w[11:7]})); d.alu = 21; d.ill = (f3 > 2); end
      7'h63: begin
        d.fmt = 3; d.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        d.alu = br_tab[f3]; d.ill = (d.alu < 0);
      end
      7'h37: begin d.fmt = 4; d.imm = {w[31:12], 12'h0}; d.alu = 10; end
      7'h17: begin d.fmt = 4; d.imm = {w[31:12], 12'h0}; d.alu = 11; end
      7'h6F: begin d.fmt = 5; d.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); d.alu = 12; end
      default: d.ill = 1;
    endcase
    if (d.ill) d.alu = 0;
    return d;
  endfunction

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } qent_t;
  qent_t mq[$];

  task automatic cmp_model();
    ref_t r;
    chk("count", 32'(qif.COUNT), 32'(mq.size()));
    chk("out_valid", 32'(qif.OUT_VALID), 32'(mq.size() != 0));
    chk("in_ready", 32'(qif.IN_READY), 32'(mq.size() != DEPTH));
    if (mq.size() != 0) begin
      r = ref_dec(mq[0].instr);
      chk("head_pc", qif.OUT_PC, mq[0].pc);
      chk("head_rd", 32'(qif.OUT_RD), 32'(mq[0].instr[11:7]));
      chk("head_rs1", 32'(qif.OUT_RS1), 32'(mq[0].instr[19:15]));
      chk("head_rs2", 32'(qif.OUT_RS2), 32'(mq[0].instr[24:20]));
      chk("head_ill", 32'(qif.OUT_ILLEGAL), 32'(r.ill));
      chk("head_alu", 32'(qif.OUT_ALU_OP), 32'(r.alu));
      if (!r.ill) begin
        chk("head_imm", qif.OUT_IMM, r.imm);
        chk("head_fmt", 32'(qif.OUT_FMT), 32'(r.fmt));
      end
    end
  endtask

  // one clock edge with the currently driven inputs, then model + compare
  task automatic tick();
    bit   do_push, do_pop, do_flush;
    qent_t e;
    do_flush = qif.FLUSH;
    do_push  = qif.IN_VALID && (mq.size() != DEPTH);
    do_pop   = qif.OUT_READY && (mq.size() != 0);
    e.instr  = qif.IN_INSTR;
    e.pc     = qif.IN_PC;
    @(posedge CLK);
    if (do_flush) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
    cmp_model();
  endtask

  // ------------------------------------------------------ vector table
  typedef struct {
    logic [31:0] instr;
    int rd, rs1, rs2;
    logic [31:0] imm;
    int fmt, alu;
    bit ill;
  } vec_t;

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) w[6:0] = ops[k];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (w[6:0] == 7'h13 && $urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  vec_t vecs [12];

  initial begin
    int mul_alu, mul_ill;
    logic [PC_W-1:0] pc;
`ifdef DECODE_QUEUE_RV32M_EN
    mul_alu = 24; mul_ill = 0;
`else
    mul_alu = 0;  mul_ill = 1;
`endif
    //           instr          rd rs1 rs2 imm           fmt alu ill
    vecs[0]  = '{32'h00500093,  1,  0,  5, 32'h00000005, 1,  0, 0};        // addi x1,x0,5
    vecs[1]  = '{32'hFE000EE3, 29,  0,  0, 32'hFFFFFFFC, 3, 14, 0};        // beq x0,x0,-4
    vecs[2]  = '{32'hFFFFF0B7,  1, 31, 31, 32'hFFFFF000, 4, 10, 0};        // lui
    vecs[3]  = '{32'h02208033,  0,  1,  2, 32'h00000000, 0, mul_alu, mul_ill[0]}; // mul
    vecs[4]  = '{32'hFFFFFFFF, 31, 31, 31, 32'h00000000, 0,  0, 1};
    vecs[5]  = '{32'h402081B3,  3,  1,  2, 32'h00000000, 0,  1, 0};        // sub
    vecs[6]  = '{32'h0020A423,  8,  1,  2, 32'h00000008, 2, 21, 0};        // sw x2,8(x1)
    vecs[7]  = '{32'h010000EF,  1,  0, 16, 32'h00000010, 5, 12, 0};        // jal x1,16
    vecs[8]  = '{32'h40335293,  5,  6,  3, 32'h00000403, 1,  7, 0};        // srai x5,x6,3
    vecs[9]  = '{32'hFFC12203,  4,  2, 28, 32'hFFFFFFFC, 1, 20, 0};        // lw x4,-4(x2)
    vecs[10] = '{32'h00002063,  0,  0,  0, 32'h00000000, 3,  0, 1};        // branch f3=2
    vecs[11] = '{32'h12345397,  7,  8,  3, 32'h12345000, 4, 11, 0};        // auipc

    RST_N = 1'b0;
    qif.FLUSH = 0; qif.IN_VALID = 0; qif.IN_INSTR = '0; qif.IN_PC = '0; qif.OUT_READY = 0;
    #12;
    chk("rst_count", 32'(qif.COUNT), 0);
    chk("rst_out_valid", 32'(qif.OUT_VALID), 0);
    chk("rst_in_ready", 32'(qif.IN_READY), 1);
    chk("rst_imm", qif.OUT_IMM, 0);
    chk("rst_pc", qif.OUT_PC, 0);
    RST_N = 1'b1;

    // table: push into empty queue, check head one cycle later, pop
    pc = 32'h1000;
    foreach (vecs[i]) begin
      qif.IN_VALID = 1; qif.IN_INSTR = vecs[i].instr; qif.IN_PC = pc; qif.OUT_READY = 0;
      tick();
      qif.IN_VALID = 0;
      chk($sformatf("v%0d_valid", i), 32'(qif.OUT_VALID), 1);
      chk($sformatf("v%0d_count", i), 32'(qif.COUNT), 1);
      chk($sformatf("v%0d_rd", i), 32'(qif.OUT_RD), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(qif.OUT_RS1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 32'(qif.OUT_RS2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_alu", i), 32'(qif.OUT_ALU_OP), 32'(vecs[i].alu));
      chk($sformatf("v%0d_ill", i), 32'(qif.OUT_ILLEGAL), 32'(vecs[i].ill));
      if (!vecs[i].ill) begin
        chk($sformatf("v%0d_imm", i), qif.OUT_IMM, vecs[i].imm);
        chk($sformatf("v%0d_fmt", i), 32'(qif.OUT_FMT), 32'(vecs[i].fmt));
      end
      chk($sformatf("v%0d_pc", i), qif.OUT_PC, pc);
      qif.OUT_READY = 1;
      tick();
      qif.OUT_READY = 0;
      pc += 4;
    end

    // fill to full, refused 5th push, full+pop refuses push, drain in order
    qif.IN_INSTR = 32'h00500093;
    for (int i = 0; i < DEPTH; i++) begin
      qif.IN_VALID = 1; qif.IN_PC = 32'h100 + 4 * i;
      tick();
    end
    chk("full_count", 32'(qif.COUNT), DEPTH);
    chk("full_in_ready", 32'(qif.IN_READY), 0);
    qif.IN_PC = 32'h200;
    tick();
    chk("full_refuse", 32'(qif.COUNT), DEPTH);
    chk("full_head", qif.OUT_PC, 32'h100);
    qif.OUT_READY = 1;
    tick();
    chk("full_pushpop_count", 32'(qif.COUNT), DEPTH - 1);
    qif.IN_VALID = 0;
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("drain_pc%0d", i), qif.OUT_PC, 32'h100 + 4 * i);
      tick();
    end
    chk("drained", 32'(qif.COUNT), 0);

    // COUNT=2, simultaneous push/pop for 10 cycles
    qif.OUT_READY = 0; qif.IN_VALID = 1;
    for (int i = 0; i < 2; i++) begin qif.IN_PC = 32'h300 + 4 * i; tick(); end
    qif.OUT_READY = 1;
    for (int i = 0; i < 10; i++) begin
      qif.IN_PC = 32'h308 + 4 * i;
      tick();
      chk("pp_count", 32'(qif.COUNT), 2);
      chk("pp_head", qif.OUT_PC, 32'h304 + 4 * i);
    end

    // COUNT=3 then FLUSH together with a push
    qif.OUT_READY = 0; qif.IN_PC = 32'h400;
    tick();
    chk("pre_flush_count", 32'(qif.COUNT), 3);
    qif.FLUSH = 1;
    chk("flush_in_ready", 32'(qif.IN_READY), 1);
    tick();
    qif.FLUSH = 0;
    chk("flush_count", 32'(qif.COUNT), 0);
    chk("flush_valid", 32'(qif.OUT_VALID), 0);

    // asynchronous reset pulse between edges
    qif.IN_PC = 32'h500;
    tick(); tick();
    qif.IN_VALID = 0;
    RST_N = 0;
    #1;
    mq.delete();
    chk("areset_count", 32'(qif.COUNT), 0);
    chk("areset_valid", 32'(qif.OUT_VALID), 0);
    chk("areset_pc", qif.OUT_PC, 0);
    RST_N = 1;
    qif.IN_VALID = 1; qif.IN_PC = 32'h600;
    tick();
    chk("post_reset_push", 32'(qif.COUNT), 1);

    // randomized traffic against the model
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      qif.FLUSH     = ($urandom_range(0, 40) == 0);
      qif.IN_VALID  = ($urandom_range(0, 3) != 0);
      qif.OUT_READY = ($urandom_range(0, 2) != 0);
      qif.IN_INSTR  = rand_instr();
      qif.IN_PC     = pc;
      pc += 4;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of decoded-instruction entries buffered; legal values are powers of two, 2 to 16.
REQ-002 Parameter PC_W, default 32: width of the program-counter field carried with each instruction.
REQ-003 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-004 Ports, listed as name, direction, width, meaning:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous discard of all buffered entries.
- IN_VALID  in  1  fetch side presents an instruction.
- IN_READY  out  1  queue can accept an instruction.
- IN_INSTR  in  32  raw RV32 instruction.
- IN_PC  in  PC_W  address of IN_INSTR.
- OUT_VALID  out  1  head entry is valid.
- OUT_READY  in  1  execute stage consumes the head entry.
- OUT_RD, OUT_RS1, OUT_RS2  out  5 each  register indices.
- OUT_IMM  out  32  sign-extended immediate.
- OUT_FMT  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
- OUT_ALU_OP  out  5  operation code (REQ-011).
- OUT_ILLEGAL  out  1  unsupported or illegal encoding.
- OUT_PC  out  PC_W  PC of the head entry.
- COUNT  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-005 The block SHALL decode IN_INSTR combinationally and write the decoded fields, together with IN_PC, into a circular buffer on any edge where IN_VALID && IN_READY.
REQ-006 Latency SHALL be one cycle: an entry written into an empty queue at edge N is presented with OUT_VALID=1 after edge N, with no combinational path from input to output.
REQ-007 IN_READY SHALL equal (COUNT != DEPTH), with no dependence on OUT_READY; a full queue does not accept a push even when it pops on the same edge.
REQ-008 OUT_VALID SHALL equal (COUNT != 0); the head SHALL pop on OUT_VALID && OUT_READY; output fields SHALL hold stable while OUT_VALID && !OUT_READY.
REQ-009 On a simultaneous push and pop, COUNT SHALL stay unchanged and both pointers SHALL advance; pointers SHALL wrap modulo DEPTH.
REQ-010 Immediates SHALL be formed from the standard RV32I bit positions, sign-extended from bit 31: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH, bit 0 = 0), U (LUI, AUIPC, low 12 bits zero), J (JAL, bit 0 = 0); OUT_IMM SHALL be 0 for the R format.
REQ-011 ALU_OP codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI, 11 AUIPC, 12 JAL, 13 JALR, 14 BEQ, 15 BNE, 16 BLT, 17 BGE, 18 BLTU, 19 BGEU, 20 LOAD, 21 STORE, 24–31 reserved for the M extension.
REQ-012 An opcode outside RV32I, or an invalid funct3/funct7 combination, SHALL set OUT_ILLEGAL=1 and ALU_OP=0; the entry SHALL still be queued in order.
REQ-013 Register fields SHALL always reflect raw bits [11:7], [19:15] and [24:20], irrespective of format.
REQ-014 When FLUSH=1 at an edge, COUNT and both pointers SHALL become 0 and any push or pop on that edge SHALL be ignored; IN_READY stays 1 during FLUSH.

Reset
REQ-015 While RST_N=0 the block SHALL hold COUNT=0, pointers=0, OUT_VALID=0 and IN_READY=1; head data fields SHALL read 0.
REQ-016 Assertion of RST_N mid-transfer SHALL discard all entries immediately; the first push is accepted on the first rising edge after deassertion.

Configuration
REQ-017 With macro DECODE_QUEUE_RV32M_EN defined, OPCODE 0110011 with funct7=0000001 SHALL decode MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU to ALU_OP 24–31 (in funct3 order) with OUT_ILLEGAL=0.
REQ-018 Without DECODE_QUEUE_RV32M_EN, those encodings SHALL set OUT_ILLEGAL=1 and ALU_OP=0.

Verification
REQ-019 Push 0x00500093 (addi x1,x0,5) into an empty queue → next cycle OUT_VALID=1, RD=1, RS1=0, IMM=5, FMT=1, ALU_OP=0, COUNT=1.
REQ-020 Push DEPTH=4 entries with OUT_READY=0 → IN_READY=0 and COUNT=4; a 5th push is refused; popping then yields the 4 entries in PC order.
REQ-021 With COUNT=2, assert push and pop together for 10 cycles → COUNT stays 2, pointers wrap, and output order is preserved.
REQ-022 Push 0xFE000EE3 (beq x0,x0,-4) → IMM=0xFFFFFFFC, FMT=3, ALU_OP=14; push 0xFFFFF0B7 → IMM=0xFFFFF000, ALU_OP=10.
REQ-023 Push 0x02208033 (mul) → ALU_OP=24 and ILLEGAL=0 with DECODE_QUEUE_RV32M_EN, ILLEGAL=1 without it; push 0xFFFFFFFF → ILLEGAL=1 in both builds.
REQ-024 With COUNT=3, assert FLUSH together with a push → next cycle COUNT=0 and OUT_VALID=0; pulse RST_N low between edges → COUNT=0 immediately.
